// File: rtl/disp_mux_pwm.sv
// ---------------------------------------------------------------------------
// disp_mux_pwm
//   Time-multiplexed N-digit seven-segment driver with integrated pattern
//   registers, global PWM brightness, per-digit blink and a display enable.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   ld         per-digit load strobe; ld[i] captures din into pattern i
//   din        pattern data (active-low raw segments, bit 7 = dp)
//   ld_bright  captures din[3:0] into the brightness register
//   bright_q   current brightness register value
//   blink      per-digit blink enable (level, sampled every cycle)
//   disp_en    0 blanks the whole display; counters keep running
//   an         registered anode enables, active-low
//   sseg       registered segment outputs, active-low
// ---------------------------------------------------------------------------
module disp_mux_pwm #(
  parameter int N_DIG      = 4,
  parameter int SEG_W      = 8,
  parameter int DWELL_BITS = 18,
  parameter int BLINK_BITS = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DIG-1:0] ld,
  input  logic [SEG_W-1:0] din,
  input  logic             ld_bright,
  output logic [3:0]       bright_q,
  input  logic [N_DIG-1:0] blink,
  input  logic             disp_en,
  output logic [N_DIG-1:0] an,
  output logic [SEG_W-1:0] sseg
);

  localparam int IDX_W = $clog2(N_DIG);

  logic [SEG_W-1:0]      pat_q [N_DIG];
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [N_DIG-1:0]      an_q, an_d;
  logic [SEG_W-1:0]      sseg_q, sseg_d;

  logic [3:0] slot;
  logic       pwm_on;
  logic       blank_blink;
  logic       vis;

  // The top four dwell bits split each dwell into 16 equal PWM slots.
  assign slot        = dwell_q[DWELL_BITS-1 -: 4];
  assign pwm_on      = (slot <= bright_q);
  assign blank_blink = blink[dig_idx_q] & blink_cnt_q[BLINK_BITS-1];
  assign vis         = disp_en & pwm_on & ~blank_blink;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    dwell_d     = dwell_q + DWELL_BITS'(1);
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    dig_idx_d   = dig_idx_q;
    an_d        = '1;
    sseg_d      = '1;

    // Explicit wrap keeps the index inside 0..N_DIG-1 for any digit count.
    if (dwell_q == '1) begin
      if (dig_idx_q == IDX_W'(N_DIG - 1)) dig_idx_d = '0;
      else                                dig_idx_d = dig_idx_q + IDX_W'(1);
    end

    if (vis) begin
      an_d   = ~(N_DIG'(1) << dig_idx_q);
      sseg_d = pat_q[dig_idx_q];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q     <= '0;
      dig_idx_q   <= '0;
      blink_cnt_q <= '0;
      an_q        <= '1;
      sseg_q      <= '1;
    end else begin
      dwell_q     <= dwell_d;
      dig_idx_q   <= dig_idx_d;
      blink_cnt_q <= blink_cnt_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

  // NOTE: the pattern store is a handful of flops, not a RAM, and must come
  // up blank, so it is reset like any other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_DIG; i++) pat_q[i] <= '1;
      bright_q <= 4'hF;
    end else begin
      for (int i = 0; i < N_DIG; i++) begin
        if (ld[i]) pat_q[i] <= din;
      end
      if (ld_bright) bright_q <= din[3:0];
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_disp_mux_pwm.sv
// ---------------------------------------------------------------------------
// tb_disp_mux_pwm
//   Scoreboard bench for disp_mux_pwm (N_DIG=4, DWELL_BITS=6, BLINK_BITS=10).
//   A posedge model derives the expected an/sseg/bright_q for each edge from
//   the cycle count since reset release and the bench's own copy of the
//   loaded patterns, and pushes it into a queue; a negedge monitor pops and
//   compares. The stimulus block adds a few hand-written directed checks.
// ---------------------------------------------------------------------------
module tb_disp_mux_pwm;

  localparam int N_DIG = 4;
  localparam int SEG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_DIG-1:0] ld = '0;
  logic [SEG_W-1:0] din = '0;
  logic             ld_bright = 1'b0;
  logic [3:0]       bright_q;
  logic [N_DIG-1:0] blink = '0;
  logic             disp_en = 1'b0;
  logic [N_DIG-1:0] an;
  logic [SEG_W-1:0] sseg;

  disp_mux_pwm #(
    .N_DIG(N_DIG), .SEG_W(SEG_W), .DWELL_BITS(6), .BLINK_BITS(10)
  ) dut (
    .clk(clk), .reset(rst_n), .ld(ld), .din(din), .ld_bright(ld_bright),
    .bright_q(bright_q), .blink(blink), .disp_en(disp_en),
    .an(an), .sseg(sseg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic [3:0] bright;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Bench model state
  int         m_t = 0;
  logic [7:0] m_pat [N_DIG];
  logic [3:0] m_bright = 4'hF;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected response for each rising edge: t = edges since release, so the
  // dwell slot, digit and blink phase follow directly from t.
  always @(posedge clk) begin
    exp_t e;
    int   dwell, dig, slot, phase;
    logic vis;
    if (!rst_n) begin
      m_t = 0;
      for (int i = 0; i < N_DIG; i++) m_pat[i] = 8'hFF;
      m_bright = 4'hF;
      q.delete();
    end else begin
      dwell = m_t % 64;
      dig   = (m_t / 64) % 4;
      slot  = dwell / 4;
      phase = (m_t / 512) % 2;
      vis   = disp_en && (slot <= int'(m_bright)) && !(blink[dig] && phase == 1);
      e.an   = vis ? ~(4'b0001 << dig) : 4'hF;
      e.sseg = vis ? m_pat[dig] : 8'hFF;
      for (int i = 0; i < N_DIG; i++) if (ld[i]) m_pat[i] = din;
      if (ld_bright) m_bright = din[3:0];
      e.bright = m_bright;
      q.push_back(e);
      m_t++;
    end
  end

  // Monitor: one expected entry per edge, compared half a cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("an", {4'h0, an}, {4'h0, e.an});
      check("sseg", sseg, e.sseg);
      check("bright_q", {4'h0, bright_q}, {4'h0, e.bright});
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] l, input logic lb, input logic [7:0] d);
    ld = l; ld_bright = lb; din = d;
    step();
    ld = '0; ld_bright = 1'b0;
  endtask

  // Advance until the model's position in the 256-clk frame hits target.
  task automatic wait_frame(input int target);
    int k;
    k = 0;
    while ((m_t % 256) != target && k < 400) begin
      step();
      k++;
    end
    if ((m_t % 256) != target) begin
      n_chk++;
      $display("FAIL wait_frame: timeout got %0d expected %0d", m_t % 256, target);
    end
  endtask

  initial begin
    // Reset, then run blank with no loads
    step(3);
    rst_n = 1'b1;
    step(1000);

    // Digits 0..3 and full brightness
    load(4'b0001, 1'b0, 8'hC0);
    load(4'b0010, 1'b0, 8'hF9);
    load(4'b0100, 1'b0, 8'hA4);
    load(4'b1000, 1'b0, 8'hB0);
    load(4'b0000, 1'b1, 8'h0F);
    check("bright_full", {4'h0, bright_q}, 8'h0F);
    disp_en = 1'b1;
    step(300);

    // Reduced brightness: 16 of 64, then 4 of 64
    load(4'b0000, 1'b1, 8'h03);
    step(1);
    check("bright_3", {4'h0, bright_q}, 8'h03);
    step(256);
    load(4'b0000, 1'b1, 8'h00);
    step(256);
    load(4'b0000, 1'b1, 8'h0F);

    // Blink digit 2 across both blink phases
    blink = 4'b0100;
    step(1100);
    blink = 4'b0000;

    // Broadcast load together with a brightness load in one cycle
    load(4'b1111, 1'b1, 8'h88);
    check("bright_8", {4'h0, bright_q}, 8'h08);
    step(300);
    load(4'b0000, 1'b1, 8'h0F);

    // Load digit 1 while it is on display: new pattern 2 clks later
    wait_frame(74);
    ld = 4'b0010; din = 8'h92;
    step();
    ld = '0;
    check("mid_dwell_old", sseg, 8'h88);
    step();
    check("mid_dwell_an", {4'h0, an}, 8'h0D);
    check("mid_dwell_new", sseg, 8'h92);
    step(200);

    // Asynchronous reset in the middle of digit 2's dwell
    wait_frame(148);
    check("pre_reset_an", {4'h0, an}, 8'h0B);
    #1 rst_n = 1'b0;
    #1;
    check("async_an", {4'h0, an}, 8'h0F);
    check("async_sseg", sseg, 8'hFF);
    check("async_bright", {4'h0, bright_q}, 8'h0F);
    step(3);
    rst_n = 1'b1;
    step(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/disp_mux_pwm.md
Name: disp_mux_pwm

Overview:
- Parametrised N-digit, time-multiplexed seven-segment LED driver with integrated pattern registers.
- Adds global brightness control via per-digit-slot PWM, per-digit blink and a global display enable.
- Sits between the board switches/buttons (or a CPU-style loader) and the anode/segment pins.

Parameters:
- N_DIG, 4, number of digits and anodes; 2..8.
- SEG_W, 8, pattern width: segments plus dp; active-low raw pattern, bit 7 = dp.
- DWELL_BITS, 18, width of the dwell counter; each digit is selected for 2^DWELL_BITS clocks; must be >= 4.
- BLINK_BITS, 25, width of the blink counter; blink half-period is 2^(BLINK_BITS-1) clocks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ld  in  N_DIG  per-digit load strobe; ld[i]=1 captures din into pattern i.
- din  in  SEG_W  pattern data.
- ld_bright  in  1  captures din[3:0] into the brightness register.
- bright_q  out  4  current brightness register value.
- blink  in  N_DIG  blink[i]=1 makes digit i blink; level input, sampled every cycle.
- disp_en  in  1  0 blanks the whole display.
- an  out  N_DIG  anode enables, active-low, registered.
- sseg  out  SEG_W  segment outputs, active-low, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - all pattern registers = all ones (blank); bright = 4'hF.
  - dwell_cnt = 0, dig_idx = 0, blink_cnt = 0.
  - an = all ones, sseg = all ones.
- Loads:
  - ld[i] writes din into pat[i] on the next clk edge.
  - Several ld bits high in the same cycle: all selected digits take the same din.
  - ld_bright is independent of ld; both may fire in the same cycle.
  - No load strobe high: registers hold.
- dwell_cnt increments by 1 every clk and wraps naturally.
- dig_idx advances when dwell_cnt is all ones: dig_idx <= (dig_idx == N_DIG-1) ? 0 : dig_idx+1.
  - dig_idx never takes a value >= N_DIG.
  - Non-power-of-two N_DIG is supported.
- PWM:
  - slot = dwell_cnt[DWELL_BITS-1 -: 4].
  - pwm_on = (slot <= bright).
  - bright = 0 gives 1/16 duty; bright = 15 gives full duty.
- Blink:
  - blink_cnt is free-running, BLINK_BITS wide, wraps naturally.
  - blink_phase = blink_cnt MSB.
  - blank_blink = blink[dig_idx] & blink_phase.
- vis = disp_en & pwm_on & ~blank_blink.
- Output register, every clk:
  - an <= vis ? ~(1 << dig_idx) : all ones.
  - sseg <= vis ? pat[dig_idx] : all ones.
  - At most one an bit is low in any cycle.
- Latency:
  - an/sseg reflect the counter and pattern state of the previous cycle (1 clk).
  - ld to visible sseg takes 2 clks, provided the digit is currently selected and vis = 1.
- Boundary conditions:
  - A load to the currently displayed digit updates sseg mid-dwell; there is no hold-off.
  - A brightness change takes effect on the next slot compare, i.e. 2 clks after ld_bright.
  - Reset asserted mid-dwell forces outputs blank immediately, asynchronously, and restarts at digit 0.
  - disp_en = 0 freezes nothing; counters keep running and only the outputs blank.

Test Plan (N_DIG=4, DWELL_BITS=6, BLINK_BITS=10):
- Reset, then release with no loads -> an=4'hF, sseg=8'hFF for 1000 clks.
- Load pat0..3 = 8'hC0, F9, A4, B0; bright=15; disp_en=1 -> an cycles 1110, 1101, 1011, 0111, each held exactly 64 clks; sseg matches the selected pattern; sequence wraps to digit 0.
- bright=3 -> within each 64-clk dwell, an active-low for the first 16 clks and 4'hF for the remaining 48; bright=0 -> 4 active clks per dwell.
- blink=4'b0100 -> digit 2 is shown during blink_cnt[9]=0 and blank (an=4'hF) during blink_cnt[9]=1; other digits are unaffected.
- ld=4'b1111 with din=8'h88 in the same cycle -> all four digits show 8'h88; ld of digit 1 while digit 1 is displayed -> sseg changes 2 clks later.
- Assert reset mid-dwell on digit 2 -> an=4'hF and sseg=8'hFF without waiting for a clk edge; after release, display restarts at digit 0 with blank patterns and bright_q=4'hF.
